keypad_matrix_scanner: RTL and testbench

- Drives the columns of the clock's 4x4 membrane keypad and reads back its rows.
- Debounces each key press and encodes it into the 4-bit key code `s` used by the time/alarm setting logic.
- Supplies the `lin`/`col` pair and a single-cycle key strobe.
- Handles the electrical end of the keypad interface; the setting logic only consumes clean codes.

---
 rtl/keypad_matrix_scanner.sv | 154 +++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scanner.sv
// 4x4 membrane keypad scanner: drives one column low at a time, synchronizes and
// debounces the rows, and emits a key code with a single-cycle strobe per accepted press.
`timescale 1ns/1ps
module keypad_matrix_scanner #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] lin,
  output logic [3:0] col,
  output logic [3:0] s,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DwellLast = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CntLast   = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {StScan, StDebounce, StPressed} state_e;

  state_e        state;
  logic [3:0]    lin_meta;
  logic [3:0]    lin_s;
  logic [3:0]    pattern;
  logic [DW-1:0] dwell;
  logic [CW-1:0] match_cnt;
  logic [CW-1:0] rel_cnt;

  logic       sample;
  logic       single_low;
  logic [3:0] lin_n;
  logic [3:0] col_next;

  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Index is {row, column}; '*' = 10, '#' = 11, the A..D column = 12..15.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = 4'd12;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = 4'd13;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = 4'd14;
      4'hC: code = 4'd10;
      4'hD: code = 4'd0;
      4'hE: code = 4'd11;
      default: code = 4'd15;
    endcase
    return code;
  endfunction

  always_comb begin
    sample     = (dwell == DwellLast);
    lin_n      = ~lin_s;
    // Exactly one row low; anything more is treated as ghosting and ignored.
    single_low = (lin_n != 4'h0) && ((lin_n & (lin_n - 4'h1)) == 4'h0);
    col_next   = {col[2:0], col[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lin_meta <= 4'hF;
      lin_s    <= 4'hF;
    end else begin
      lin_meta <= lin;
      lin_s    <= lin_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StScan;
      col       <= 4'b1110;
      s         <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      pattern   <= 4'hF;
      dwell     <= '0;
      match_cnt <= '0;
      rel_cnt   <= '0;
    end else begin
      key_valid <= 1'b0;
      dwell     <= sample ? '0 : dwell + DW'(1);
      if (sample) begin
        case (state)
          StScan: begin
            if (single_low) begin
              pattern   <= lin_s;
              match_cnt <= CW'(1);
              state     <= StDebounce;
            end else begin
              col <= col_next;
            end
          end
          StDebounce: begin
            if (lin_s == pattern) begin
              if (match_cnt == CntLast) begin
                s         <= key_code(low_index(pattern), low_index(col));
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                match_cnt <= '0;
                rel_cnt   <= '0;
                state     <= StPressed;
              end else begin
                match_cnt <= match_cnt + CW'(1);
              end
            end else begin
              match_cnt <= '0;
              col       <= col_next;
              state     <= StScan;
            end
          end
          StPressed: begin
            // Column stays frozen on the held key, so other keys are invisible here.
            if (lin_s == 4'hF) begin
              if (rel_cnt == CntLast) begin
                rel_cnt  <= '0;
                key_held <= 1'b0;
                col      <= col_next;
                state    <= StScan;
              end else begin
                rel_cnt <= rel_cnt + CW'(1);
              end
            end else begin
              rel_cnt <= '0;
            end
          end
          default: state <= StScan;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench for keypad_matrix_scanner: a keypad model drives the rows, expected
// key codes are queued at press time and checked by an independent monitor.
`timescale 1ns/1ps
module tb_keypad_matrix_scanner;
  localparam int SD = 4;
  localparam int DB = 3;
  localparam int MaxLat = 4 * SD + 2 + (DB - 1) * SD;
  localparam int MinLat = 3 + (DB - 1) * SD;
  localparam int MaxRel = 2 + SD + (DB - 1) * SD;
  localparam int MinRel = 3 + (DB - 1) * SD;

  logic       clk;
  logic       rst_n;
  logic [3:0] lin;
  logic [3:0] col;
  logic [3:0] s;
  logic       key_valid;
  logic       key_held;

  keypad_matrix_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lin       (lin),
    .col       (col),
    .s         (s),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Physical keypad: a pressed key shorts its row to its column when that column is driven.
  logic [15:0] pressed;
  logic        force_en;
  logic [3:0]  force_val;
  always_comb begin
    lin = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) lin[r] = 1'b0;
    if (force_en) lin = force_val;
  end

  int keymap[16];

  typedef struct {
    int code;
    int stamp;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int passes = 0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor
  logic prev_kv;
  logic [3:0] prev_s;
  exp_t mon_e;
  int mon_lat;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_kv = 1'b0;
      prev_s  = s;
    end else begin
      check($countones(~col) == 1, "col_one_low", col, 0);
      if (key_valid) begin
        check(!prev_kv, "kv_single_cycle", prev_kv, 0);
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_key_valid", s, -1);
        end else begin
          mon_e = exp_q.pop_front();
          check(s == mon_e.code, "key_code", s, mon_e.code);
          mon_lat = cyc - mon_e.stamp;
          check(mon_lat >= MinLat && mon_lat <= MaxLat, "press_latency", mon_lat, MaxLat);
        end
      end else begin
        check(s == prev_s, "s_stable_without_kv", s, prev_s);
      end
      prev_kv = key_valid;
      prev_s  = s;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int k);
    exp_t e;
    e.code  = keymap[k];
    e.stamp = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_pulse(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < MaxLat + 10; i++) begin
      @(negedge clk);
      if (key_valid) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    check(seen, name, seen, 1);
    if (!seen) exp_q.delete();
  endtask

  task automatic wait_release(output int lat);
    lat = -1;
    for (int i = 1; i <= MaxRel + 6; i++) begin
      step(1);
      if (!key_held) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_col_entry(input logic [3:0] target, output bit ok);
    logic [3:0] prev = col;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (col == target && prev != target) begin
        ok = 1'b1;
        break;
      end
      prev = col;
    end
  endtask

  task automatic press_key(input int k, input int hold);
    bit held_ok = 1'b1;
    int lat;
    logic [3:0] exp_col;
    pressed[k] = 1'b1;
    push_exp(k);
    wait_pulse("pulse_seen");
    for (int i = 0; i < hold; i++) begin
      step(1);
      if (!key_held) held_ok = 1'b0;
    end
    check(held_ok, "held_during_hold", held_ok, 1);
    pressed[k] = 1'b0;
    wait_release(lat);
    check(lat >= MinRel && lat <= MaxRel, "release_latency", lat, MaxRel);
    check(s == keymap[k], "s_kept_after_release", s, keymap[k]);
    exp_col = ~(4'b0001 << ((k + 1) % 4));
    check(col == exp_col, "col_advances_on_release", col, exp_col);
  endtask

  initial begin
    bit ok;
    int lat;
    logic [3:0] exp_col;
    keymap    = '{1, 2, 3, 12, 4, 5, 6, 13, 7, 8, 9, 14, 10, 0, 11, 15};
    pressed   = '0;
    force_en  = 1'b0;
    force_val = 4'hF;
    rst_n     = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(7);

    // Asynchronous reset mid-scan, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check(col == 4'b1110, "reset_col", col, 4'b1110);
    check(s == 4'h0, "reset_s", s, 0);
    check(key_valid == 1'b0, "reset_kv", key_valid, 0);
    check(key_held == 1'b0, "reset_held", key_held, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle rotation: one column step per SD cycles
    for (int k = 1; k <= 64; k++) begin
      step(1);
      exp_col = ~(4'b0001 << ((k / SD) % 4));
      check(col == exp_col, "idle_rotation", col, exp_col);
    end

    press_key(5, 200);

    // Single bouncy sample in column 0: DEBOUNCE is entered then abandoned
    wait_col_entry(4'b1110, ok);
    check(ok, "col0_entry_bounce", ok, 1);
    force_val = 4'b1110;
    force_en  = 1'b1;
    step(SD);
    force_en  = 1'b0;
    step(SD);
    check(col == 4'b1101, "bounce_resumes_scan", col, 4'b1101);
    press_key(14, 20);

    // Two rows low in column 0: not a key, rotation continues on time
    wait_col_entry(4'b1110, ok);
    check(ok, "col0_entry_ghost", ok, 1);
    force_val = 4'b1010;
    force_en  = 1'b1;
    step(SD);
    force_en  = 1'b0;
    check(col == 4'b1101, "ghost_no_debounce", col, 4'b1101);

    // '1' held, then '2' added: only '1' reported
    pressed[0] = 1'b1;
    push_exp(0);
    wait_pulse("pulse_key1");
    pressed[1] = 1'b1;
    step(40);
    check(key_held == 1'b1, "held_with_second_key", key_held, 1);
    pressed[0] = 1'b0;
    pressed[1] = 1'b0;
    wait_release(lat);
    check(lat >= MinRel && lat <= MaxRel, "release_two_keys", lat, MaxRel);
    press_key(1, 10);

    // Reset while PRESSED, key still down afterwards
    pressed[3] = 1'b1;
    push_exp(3);
    wait_pulse("pulse_keyA");
    step(3);
    #2 rst_n = 1'b0;
    #1;
    check(s == 4'h0, "reset_pressed_s", s, 0);
    check(key_held == 1'b0, "reset_pressed_held", key_held, 0);
    check(col == 4'b1110, "reset_pressed_col", col, 4'b1110);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_exp(3);
    wait_pulse("pulse_keyA_after_reset");
    pressed[3] = 1'b0;
    wait_release(lat);
    check(lat >= MinRel && lat <= MaxRel, "release_keyA", lat, MaxRel);

    for (int n = 0; n < 16; n++) begin
      press_key(int'($urandom_range(0, 15)), int'($urandom_range(1, 20)));
      step(int'($urandom_range(0, 9)));
    end

    step(20);
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
